ped_crossing_ctrl: RTL and testbench
====================================

// Module: ped_crossing_ctrl
// PURPOSE
//  Pedestrian-side partner of the traffic-light FSM. Debounces the crossing push-button and latches the request.
//  Drives the request (Solicitud) into the FSM's IN input and consumes that FSM's Pasar_Persona and lamp outputs.
//  Sequences the pedestrian lamps: walk, flashing walk, clear.
//  Holds the walk lamp off whenever the vehicle red lamp is not lit.
// PARAMETERS
//  DEBOUNCE_CYC  4  consecutive identical synced samples needed to accept a new button level (>=1)
//  WALK_CYC      8  cycles spent in P_WALK (>=1)
//  FLASH_CYC     6  cycles spent in P_FLASH (>=1)
//  FLASH_HALF    2  cycles per half-period of the flashing walk lamp (>=1)
//  CNT_W         8  counter width; must hold max(DEBOUNCE_CYC, WALK_CYC, FLASH_CYC)
// PORTS
//  Clk            in   1  clock, rising edge
//  Reset          in   1  synchronous, active-high
//  Boton          in   1  raw push-button, asynchronous, active-high
//  Rojo_In        in   1  vehicle red lamp from traffic FSM
//  Pasar_Persona  in   1  crossing grant from traffic FSM (1-cycle pulse)
//  Solicitud      out  1  crossing request, connects to traffic FSM IN
//  Peaton_Verde   out  1  pedestrian walk lamp
//  Peaton_Rojo    out  1  pedestrian don't-walk lamp
//  Espera_Led     out  1  "request registered" indicator
//  Falla          out  1  sticky safety fault
//  Estado_Salida  out  3  current state, for TB: IDLE=0 PEND=1 WALK=2 FLASH=3 CLEAR=4
// BEHAVIOUR
//  Reset (synchronous, active-high, clock Clk): applies at the next edge and overrides everything, including mid-operation.
//   Reset state: state=IDLE, sync flops=0, debounced level=0, all counters=0, pend_next=0, Falla=0.
//   Outputs after reset: Peaton_Rojo=1; Solicitud, Peaton_Verde and Espera_Led=0.
//  Input path: Boton passes through a 2-flop synchroniser.
//   The debounced level changes only after DEBOUNCE_CYC consecutive synced samples differ from it.
//   A press event is a 0->1 change of the debounced level.
//   Latency: with Boton stable at 1, Solicitud rises at edge 3+DEBOUNCE_CYC, counting the first edge that samples Boton=1 as edge 0.
//  Output decode: outputs are Moore, decoded from registered state, flash bit and pend_next only.
//  States:
//   IDLE:  Peaton_Rojo=1. Press event -> PEND.
//   PEND:  Solicitud=1, Espera_Led=1, Peaton_Rojo=1.
//          Pasar_Persona=1 and Rojo_In=1 -> WALK; load counter WALK_CYC-1.
//          Pasar_Persona=1 and Rojo_In=0 -> stay in PEND and set Falla.
//   WALK:  Peaton_Verde=1, Solicitud=0. Counter decrements each cycle; at 0 -> FLASH.
//          On entry to FLASH: load counter FLASH_CYC-1, flash bit=1, half-period counter=FLASH_HALF-1.
//   FLASH: Peaton_Verde=flash bit; Peaton_Rojo=0.
//          Flash bit toggles each time the half-period counter reaches 0, and the half-period counter reloads.
//          Main counter at 0 -> CLEAR.
//   CLEAR: exactly 1 cycle. Peaton_Rojo=1, Peaton_Verde=0.
//          Next state is PEND if pend_next=1, else IDLE; pend_next clears.
//  Press event in WALK, FLASH or CLEAR: sets pend_next, so Espera_Led=1. Further presses are absorbed, not counted.
//  Press event in PEND: ignored, request already held.
//  Safety: Rojo_In=0 at any edge while in WALK or FLASH -> next state IDLE.
//   Falla is set, pend_next is cleared, Peaton_Verde=0 from that edge.
//  Falla is sticky until Reset and does not block further operation.
//  Invariants: Peaton_Verde and Peaton_Rojo are never both 1. Solicitud=1 only in PEND.
//  Counter arithmetic: unsigned CNT_W, no wrap; counters decrement only while in their owning state.
//  Unused state encodings (5-7) -> IDLE at next edge.
// TESTING
//  T1 reset: Reset=1 for 2 cycles -> Estado_Salida=0, Peaton_Rojo=1, all other outputs 0.
//  T2 glitch: Boton=1 for 3 cycles then 0 (DEBOUNCE_CYC=4) -> Solicitud stays 0 and state stays IDLE for 20 cycles.
//  T3 full cycle: Boton=1 for 10 cycles -> Solicitud=1 at edge 7.
//     Then Pasar_Persona pulse with Rojo_In=1 -> Peaton_Verde=1 for 8 cycles (WALK).
//     FLASH walk lamp pattern is 1,1,0,0,1,1; then CLEAR for 1 cycle; then Estado_Salida=0.
//  T4 queued request: press during WALK -> Espera_Led=1, and after CLEAR the block is in PEND (Estado_Salida=1) with Solicitud=1.
//  T5 safety: Rojo_In 1->0 at WALK cycle 3 -> next edge Estado_Salida=0, Peaton_Verde=0, Peaton_Rojo=1.
//     Falla=1 and stays 1 through a later complete T3 sequence.
//  T6 reset mid-FLASH: Reset=1 in FLASH cycle 2 -> next edge IDLE, Falla=0, pend_next=0, counters 0.

Source files
------------

// File: rtl/ped_crossing_ctrl_if.sv
// Pedestrian crossing bundle: button and traffic-FSM inputs, lamp/request/status outputs.
// slave = crossing controller, master = environment driving the button and traffic-FSM side.
interface ped_crossing_ctrl_if;
  logic       Boton;
  logic       Rojo_In;
  logic       Pasar_Persona;
  logic       Solicitud;
  logic       Peaton_Verde;
  logic       Peaton_Rojo;
  logic       Espera_Led;
  logic       Falla;
  logic [2:0] Estado_Salida;

  modport master (
    output Boton, Rojo_In, Pasar_Persona,
    input  Solicitud, Peaton_Verde, Peaton_Rojo, Espera_Led, Falla, Estado_Salida
  );

  modport slave (
    input  Boton, Rojo_In, Pasar_Persona,
    output Solicitud, Peaton_Verde, Peaton_Rojo, Espera_Led, Falla, Estado_Salida
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounced button request, walk/flash/clear lamp sequencing, red-lamp safety.
// Request rises 3+DEBOUNCE_CYC edges after the button is first sampled high; outputs are Moore, no backpressure.
module ped_crossing_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int WALK_CYC     = 8,
  parameter int FLASH_CYC    = 6,
  parameter int FLASH_HALF   = 2,
  parameter int CNT_W        = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  ped_crossing_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_WALK  = 3'd2,
    S_FLASH = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               lvl_q, lvl_d;
  logic               lvl_prev_q, lvl_prev_d;
  logic               press_q, press_d;
  logic [CNT_W-1:0]   dbc_q, dbc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic               flash_q, flash_d;
  logic               pend_q, pend_d;
  logic               falla_q, falla_d;

  // Press is registered one extra stage so the FSM only ever sees a clean flop output.
  always_comb begin
    sync1_d    = bus.Boton;
    sync2_d    = sync1_q;
    lvl_d      = lvl_q;
    dbc_d      = '0;
    lvl_prev_d = lvl_q;
    press_d    = lvl_q & ~lvl_prev_q;
    if (sync2_q != lvl_q) begin
      if (dbc_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        lvl_d = sync2_q;
      end else begin
        dbc_d = dbc_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    flash_d = flash_q;
    pend_d  = pend_q;
    falla_d = falla_q;
    case (state_q)
      S_IDLE: begin
        if (press_q) state_d = S_PEND;
      end
      S_PEND: begin
        if (bus.Pasar_Persona) begin
          if (bus.Rojo_In) begin
            state_d = S_WALK;
            cnt_d   = CNT_W'(WALK_CYC - 1);
          end else begin
            falla_d = 1'b1;
          end
        end
      end
      S_WALK: begin
        if (press_q) pend_d = 1'b1;
        if (!bus.Rojo_In) begin
          state_d = S_IDLE;
          falla_d = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_FLASH;
          cnt_d   = CNT_W'(FLASH_CYC - 1);
          half_d  = CNT_W'(FLASH_HALF - 1);
          flash_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FLASH: begin
        if (press_q) pend_d = 1'b1;
        if (!bus.Rojo_In) begin
          state_d = S_IDLE;
          falla_d = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = '0;
          half_d  = '0;
          flash_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_CLEAR;
          half_d  = '0;
          flash_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (half_q == '0) begin
            flash_d = ~flash_q;
            half_d  = CNT_W'(FLASH_HALF - 1);
          end else begin
            half_d = half_q - CNT_W'(1);
          end
        end
      end
      S_CLEAR: begin
        // A press landing in the clear cycle itself still queues the next crossing.
        state_d = (pend_q || press_q) ? S_PEND : S_IDLE;
        pend_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        half_d  = '0;
        flash_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      press_q    <= 1'b0;
      dbc_q      <= '0;
      cnt_q      <= '0;
      half_q     <= '0;
      flash_q    <= 1'b0;
      pend_q     <= 1'b0;
      falla_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      press_q    <= press_d;
      dbc_q      <= dbc_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      flash_q    <= flash_d;
      pend_q     <= pend_d;
      falla_q    <= falla_d;
    end
  end

  // Walk lamp only in WALK/FLASH, so it is dark the edge after a safety exit.
  assign bus.Solicitud     = (state_q == S_PEND);
  assign bus.Espera_Led    = (state_q == S_PEND) || pend_q;
  assign bus.Peaton_Verde  = (state_q == S_WALK) || ((state_q == S_FLASH) && flash_q);
  assign bus.Peaton_Rojo   = !((state_q == S_WALK) || (state_q == S_FLASH));
  assign bus.Falla         = falla_q;
  assign bus.Estado_Salida = state_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: vector table for reset and a full crossing, hand sequences for corner cases.
module tb_ped_crossing_ctrl;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  ped_crossing_ctrl_if bus ();

  ped_crossing_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       rojo;
    logic       pasar;
    logic [2:0] est;
    logic       sol;
    logic       pv;
    logic       pr;
    logic       esp;
    logic       fal;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, btn, rojo, pasar, input logic [2:0] est,
                         input logic sol, pv, pr, esp, fal);
    vec_t v;
    v.rst = rst; v.btn = btn; v.rojo = rojo; v.pasar = pasar;
    v.est = est; v.sol = sol; v.pv = pv; v.pr = pr; v.esp = esp; v.fal = fal;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, b, rj, p);
    @(negedge Clk);
    Reset             = r;
    bus.Boton         = b;
    bus.Rojo_In       = rj;
    bus.Pasar_Persona = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic to_pend(input string tag);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk({tag, " pend state"}, bus.Estado_Salida, 3'd1);
    chk({tag, " pend solicitud"}, 3'(bus.Solicitud), 3'd1);
  endtask

  // Button released for four cycles so the debounced level drops; q re-presses from the grant cycle.
  task automatic to_walk(input logic q, input string tag);
    to_pend(tag);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, q, 1'b1, 1'b1);
    chk({tag, " walk entry"}, bus.Estado_Salida, 3'd2);
    chk({tag, " walk lamp"}, 3'(bus.Peaton_Verde), 3'd1);
  endtask

  task automatic run_out(input logic q, input logic exp_fal, input string tag);
    logic [5:0] pat;
    pat = 6'b110011;
    for (int i = 1; i < 8; i++) begin
      step(1'b0, q, 1'b1, 1'b0);
      chk($sformatf("%s walk%0d verde", tag, i), 3'(bus.Peaton_Verde), 3'd1);
    end
    chk({tag, " walk7 espera"}, 3'(bus.Espera_Led), 3'(q));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("%s flash%0d verde", tag, i), 3'(bus.Peaton_Verde), 3'(pat[5-i]));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk({tag, " clear state"}, bus.Estado_Salida, 3'd4);
    chk({tag, " clear rojo"}, 3'(bus.Peaton_Rojo), 3'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk({tag, " after clear state"}, bus.Estado_Salida, q ? 3'd1 : 3'd0);
    chk({tag, " after clear solicitud"}, 3'(bus.Solicitud), 3'(q));
    chk({tag, " falla"}, 3'(bus.Falla), 3'(exp_fal));
  endtask

  initial begin
    logic [5:0] pat;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.Boton = 1'b0;
    bus.Rojo_In = 1'b1;
    bus.Pasar_Persona = 1'b0;

    // Reset, then button held 10 cycles, grant at edge 12, full walk/flash/clear.
    pat = 6'b110011;
    add_vec(1, 0, 1, 0, 3'd0, 0, 0, 1, 0, 0);
    add_vec(1, 0, 1, 0, 3'd0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 7; k++) add_vec(0, 1, 1, 0, 3'd0, 0, 0, 1, 0, 0);
    for (int k = 7; k < 10; k++) add_vec(0, 1, 1, 0, 3'd1, 1, 0, 1, 1, 0);
    for (int k = 10; k < 12; k++) add_vec(0, 0, 1, 0, 3'd1, 1, 0, 1, 1, 0);
    add_vec(0, 0, 1, 1, 3'd2, 0, 1, 0, 0, 0);
    for (int k = 13; k < 20; k++) add_vec(0, 0, 1, 0, 3'd2, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) add_vec(0, 0, 1, 0, 3'd3, 0, pat[5-k], 0, 0, 0);
    add_vec(0, 0, 1, 0, 3'd4, 0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 0, 3'd0, 0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].btn, vecs[i].rojo, vecs[i].pasar);
      chk($sformatf("vec%0d estado", i), bus.Estado_Salida, vecs[i].est);
      chk($sformatf("vec%0d solicitud", i), 3'(bus.Solicitud), 3'(vecs[i].sol));
      chk($sformatf("vec%0d verde", i), 3'(bus.Peaton_Verde), 3'(vecs[i].pv));
      chk($sformatf("vec%0d rojo", i), 3'(bus.Peaton_Rojo), 3'(vecs[i].pr));
      chk($sformatf("vec%0d espera", i), 3'(bus.Espera_Led), 3'(vecs[i].esp));
      chk($sformatf("vec%0d falla", i), 3'(bus.Falla), 3'(vecs[i].fal));
    end

    // Glitch shorter than the debounce window.
    for (int i = 0; i < 23; i++) begin
      step(1'b0, (i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      chk($sformatf("glitch%0d estado", i), bus.Estado_Salida, 3'd0);
      chk($sformatf("glitch%0d solicitud", i), 3'(bus.Solicitud), 3'd0);
    end

    // Press during WALK queues the next crossing.
    to_walk(1'b1, "queued");
    run_out(1'b1, 1'b0, "queued");
    chk("queued espera in pend", 3'(bus.Espera_Led), 3'd1);

    // Red lamp lost at WALK cycle 3.
    do_reset();
    chk("reset2 estado", bus.Estado_Salida, 3'd0);
    to_walk(1'b0, "safety");
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("safety walk%0d", i), bus.Estado_Salida, 3'd2);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("safety estado", bus.Estado_Salida, 3'd0);
    chk("safety verde", 3'(bus.Peaton_Verde), 3'd0);
    chk("safety rojo", 3'(bus.Peaton_Rojo), 3'd1);
    chk("safety falla", 3'(bus.Falla), 3'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    to_walk(1'b0, "sticky");
    run_out(1'b0, 1'b1, "sticky");

    // Reset during FLASH cycle 2 with a queued request.
    to_walk(1'b1, "midflash");
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midflash espera queued", 3'(bus.Espera_Led), 3'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("midflash in flash", bus.Estado_Salida, 3'd3);
    chk("midflash falla before reset", 3'(bus.Falla), 3'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("midflash reset estado", bus.Estado_Salida, 3'd0);
    chk("midflash reset falla", 3'(bus.Falla), 3'd0);
    chk("midflash reset espera", 3'(bus.Espera_Led), 3'd0);
    chk("midflash reset verde", 3'(bus.Peaton_Verde), 3'd0);
    chk("midflash reset rojo", 3'(bus.Peaton_Rojo), 3'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("midflash stays idle", bus.Estado_Salida, 3'd0);
    chk("midflash no pending", 3'(bus.Espera_Led), 3'd0);

    // Grant with vehicle red off while pending.
    to_pend("grantfault");
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("grantfault estado", bus.Estado_Salida, 3'd1);
    chk("grantfault falla", 3'(bus.Falla), 3'd1);
    chk("grantfault verde", 3'(bus.Peaton_Verde), 3'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("grantfault later walk", bus.Estado_Salida, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
